// File: rtl/lab_io_pkg.sv
// Shared types for the lab I/O blocks: FSM state encodings
// and the default data width of the switch word.
package lab_io_pkg;

  localparam int DATA_W_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE         = 2'd0;
  localparam state_t WAIT_RELEASE = 2'd1;
  localparam state_t WAIT_PRESS   = 2'd2;
  localparam state_t DONE         = 2'd3;

endpackage

// File: rtl/edge_rise_detect.sv
// Rising-edge detector for a clock-synchronous level.
// Ports: clock, reset (sync, active-high), level in;
//        rise (combinational), pulse_q (rise delayed one cycle).
module edge_rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic pulse_q
);

  logic btn_q;

  assign rise = level & ~btn_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      btn_q   <= level;
      pulse_q <= rise;
    end
  end

endmodule

// File: rtl/input_confirm_unit.sv
// Completes the CPU IN instruction: on in_req waits for a fresh press,
// latches chaves into dado_out and raises in_done (4-phase handshake).
// Ports: clock, reset (sync, active-high), botaoFiltrado, chaves,
//        in_req -> in_done, dado_out, aguardando, press_pulse, in_timeout.
// Macro INPUT_CONFIRM_TIMEOUT_EN adds a WAIT_PRESS timeout that returns
// DEFAULT_VAL; without it in_timeout is tied low.
module input_confirm_unit
  import lab_io_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef INPUT_CONFIRM_TIMEOUT_EN
  ,
  parameter int                 TIMEOUT_W   = 32,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 32'd500000000,
  parameter logic [DATA_W-1:0]  DEFAULT_VAL = {DATA_W{1'b0}}
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              botaoFiltrado,
  input  logic [DATA_W-1:0] chaves,
  input  logic              in_req,
  output logic              in_done,
  output logic [DATA_W-1:0] dado_out,
  output logic              aguardando,
  output logic              press_pulse,
  output logic              in_timeout
);

  state_t state, state_nxt;
  logic   rise;
  logic   cap_press;
  logic   cap_to;

  edge_rise_detect u_edge (
    .clock   (clock),
    .reset   (reset),
    .level   (botaoFiltrado),
    .rise    (rise),
    .pulse_q (press_pulse)
  );

  // Abort (in_req low) takes priority over any capture.
  assign cap_press = (state == WAIT_PRESS) & in_req & rise;

`ifdef INPUT_CONFIRM_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TERM =
    TIMEOUT_MAX - {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [TIMEOUT_W-1:0] cnt;
  logic                 to_q;

  // A press on the terminal cycle wins over the timeout.
  assign cap_to = (state == WAIT_PRESS) & in_req
                & ~rise & (cnt == TERM);

  always_ff @(posedge clock) begin
    if (reset || state != WAIT_PRESS)
      cnt <= '0;
    else
      cnt <= cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clock) begin
    if (reset)
      to_q <= 1'b0;
    else if (cap_to)
      to_q <= 1'b1;
    else if (cap_press || (state == DONE && !in_req))
      to_q <= 1'b0;
  end

  assign in_timeout = to_q;
`else
  assign cap_to     = 1'b0;
  assign in_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_req) state_nxt = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!in_req)            state_nxt = IDLE;
        else if (!botaoFiltrado) state_nxt = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!in_req)                state_nxt = IDLE;
        else if (cap_press || cap_to) state_nxt = DONE;
      end
      DONE: begin
        if (!in_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_done    = (state == DONE);
    aguardando = (state == WAIT_RELEASE)
               | (state == WAIT_PRESS);
  end

  always_ff @(posedge clock) begin
    if (reset)
      dado_out <= '0;
    else if (cap_press)
      dado_out <= chaves;
`ifdef INPUT_CONFIRM_TIMEOUT_EN
    else if (cap_to)
      dado_out <= DEFAULT_VAL;
`endif
  end

endmodule

// File: tb/tb_input_confirm_unit.sv
// Directed bench for input_confirm_unit: handshake, held-button
// rejection, abort, press pulses and (with macro) timeout.
module tb_input_confirm_unit;

  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          botaoFiltrado;
  logic [DW-1:0] chaves;
  logic          in_req;
  logic          in_done;
  logic [DW-1:0] dado_out;
  logic          aguardando;
  logic          press_pulse;
  logic          in_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  input_confirm_unit #(
    .DATA_W (DW)
`ifdef INPUT_CONFIRM_TIMEOUT_EN
    , .TIMEOUT_W   (32)
    , .TIMEOUT_MAX (32'd8)
    , .DEFAULT_VAL (16'h0000)
`endif
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .botaoFiltrado (botaoFiltrado),
    .chaves        (chaves),
    .in_req        (in_req),
    .in_done       (in_done),
    .dado_out      (dado_out),
    .aguardando    (aguardando),
    .press_pulse   (press_pulse),
    .in_timeout    (in_timeout)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; botaoFiltrado = 1'b1;
    in_req = 1'b1; chaves = 16'h0000;
    tick(2);
    // 1: reset overrides held button and request
    check("rst_done", in_done, 0);
    check("rst_dado", dado_out, 0);
    check("rst_wait", aguardando, 0);
    check("rst_pulse", press_pulse, 0);
    check("rst_to", in_timeout, 0);
    reset = 1'b0;
    tick();
    check("t1_wrel", aguardando, 1);
    // 3: held button never confirms
    tick(4);
    check("t3_held_wait", aguardando, 1);
    check("t3_held_done", in_done, 0);
    botaoFiltrado = 1'b0;
    tick();
    chaves = 16'h0042; botaoFiltrado = 1'b1;
    tick();
    check("t3_done", in_done, 1);
    check("t3_dado", dado_out, 16'h0042);
    check("t3_pulse", press_pulse, 1);
    in_req = 1'b0;
    tick();
    check("t3_drop", in_done, 0);
    check("t3_keep", dado_out, 16'h0042);
    // 2: basic handshake
    botaoFiltrado = 1'b0;
    tick();
    in_req = 1'b1; chaves = 16'hA5C3;
    tick(2);
    check("t2_wpress", aguardando, 1);
    check("t2_nodone", in_done, 0);
    botaoFiltrado = 1'b1;
    tick();
    check("t2_done", in_done, 1);
    check("t2_dado", dado_out, 16'hA5C3);
    chaves = 16'hFFFF;
    tick();
    check("t2_stable", dado_out, 16'hA5C3);
    check("t2_pulse1", press_pulse, 0);
    in_req = 1'b0;
    tick();
    check("t2_drop", in_done, 0);
    in_req = 1'b1;
    tick();
    check("t2_rereq", aguardando, 1);
    // 4: abort during WAIT_PRESS
    botaoFiltrado = 1'b0;
    tick();
    in_req = 1'b0;
    tick();
    check("t4_idle", aguardando, 0);
    chaves = 16'h1234; botaoFiltrado = 1'b1;
    tick();
    check("t4_pulse", press_pulse, 1);
    check("t4_nodone", in_done, 0);
    check("t4_dado", dado_out, 16'hA5C3);
    tick();
    check("t4_pulse_end", press_pulse, 0);
    // 5: two presses 3 cycles apart in IDLE
    botaoFiltrado = 1'b0;
    tick();
    botaoFiltrado = 1'b1;
    tick();
    check("t5_p1", press_pulse, 1);
    botaoFiltrado = 1'b0;
    tick();
    check("t5_gap1", press_pulse, 0);
    tick();
    check("t5_gap2", press_pulse, 0);
    botaoFiltrado = 1'b1;
    tick();
    check("t5_p2", press_pulse, 1);
    tick();
    check("t5_end", press_pulse, 0);
    check("t5_idle", aguardando, 0);
    check("t5_nodone", in_done, 0);
`ifdef INPUT_CONFIRM_TIMEOUT_EN
    // 6: timeout with no press, then press on terminal cycle
    botaoFiltrado = 1'b0; in_req = 1'b1;
    tick(2);
    tick(7);
    check("t6_pre", in_done, 0);
    tick();
    check("t6_done", in_done, 1);
    check("t6_to", in_timeout, 1);
    check("t6_dado", dado_out, 16'h0000);
    in_req = 1'b0;
    tick();
    check("t6_to_clr", in_timeout, 0);
    in_req = 1'b1;
    tick(2);
    tick(7);
    chaves = 16'hBEEF; botaoFiltrado = 1'b1;
    tick();
    check("t6b_done", in_done, 1);
    check("t6b_to", in_timeout, 0);
    check("t6b_dado", dado_out, 16'hBEEF);
    in_req = 1'b0;
    tick();
`endif
    // reset mid-request clears captured data
    botaoFiltrado = 1'b0; in_req = 1'b1;
    tick(2);
    chaves = 16'h5A5A; botaoFiltrado = 1'b1;
    tick();
    check("r_done", in_done, 1);
    reset = 1'b1;
    tick();
    check("r_done0", in_done, 0);
    check("r_dado0", dado_out, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
